// File: rtl/ring_input_buffer.sv
// ----------------------------------------------------------------------------
// ring_input_buffer
//
// Router input stage sitting directly behind the NIC or the previous ring
// router. Incoming 64-bit packets are written into one of two virtual-channel
// FIFOs (even/odd). The global polarity bit picks which VC may be written and
// which may be read in a given cycle. The head packet of the read VC goes to
// the local PE port when its hop count is zero. Otherwise it goes to the
// forward ring port, with the hop count decremented on the way out.
//
// Ports
//   clk       in   1          rising-edge clock
//   reset     in   1          asynchronous, active-low reset
//   polarity  in   1          0 = even cycle (write even / read odd),
//                             1 = odd cycle  (write odd  / read even)
//   in_si     in   1          upstream send valid
//   in_ri     out  1          ready to upstream (write VC not full)
//   in_di     in   64         packet: [63]=vc [62]=dir [61:56]=rsvd
//                             [55:48]=hop [47:0]=payload
//   loc_so    out  1          head valid and destined for the local PE
//   loc_ro    in   1          local port ready
//   fwd_so    out  1          head valid and destined for the ring
//   fwd_ro    in   1          forward port ready
//   out_do    out  64         head packet (hop-1 when forwarding)
//   occ_even  out  PTR_W+1    even-VC occupancy
//   occ_odd   out  PTR_W+1    odd-VC occupancy
//   err_vc    out  1          sticky: accepted packet whose vc bit != write VC
// ----------------------------------------------------------------------------
module ring_input_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             polarity,
    input  logic             in_si,
    output logic             in_ri,
    input  logic [63:0]      in_di,
    output logic             loc_so,
    input  logic             loc_ro,
    output logic             fwd_so,
    input  logic             fwd_ro,
    output logic [63:0]      out_do,
    output logic [PTR_W:0]   occ_even,
    output logic [PTR_W:0]   occ_odd,
    output logic             err_vc
);

    localparam logic [PTR_W:0] L_FULL = (PTR_W + 1)'(DEPTH);

    // Per-VC state, index 0 = even VC, index 1 = odd VC.
    logic [63:0]      r_mem    [2][DEPTH];
    logic [PTR_W-1:0] r_wr_ptr [2];
    logic [PTR_W-1:0] r_rd_ptr [2];
    logic [PTR_W:0]   r_occ    [2];
    logic             r_err_vc;

    logic             w_wv;
    logic             w_rv;
    logic             w_push;
    logic             w_pop;
    logic             w_head_valid;
    logic             w_is_local;
    logic [63:0]      w_head;
    logic [7:0]       w_hop_dec;

    // The write and read VCs are always different, so a FIFO never sees a
    // push and a pop in the same cycle.
    assign w_wv = polarity;
    assign w_rv = ~polarity;

    // in_ri is gated by reset so that upstream never observes ready while
    // the block is held in reset.
    assign in_ri  = reset && (r_occ[w_wv] != L_FULL);
    assign w_push = in_si && in_ri;

    assign w_head       = r_mem[w_rv][r_rd_ptr[w_rv]];
    assign w_head_valid = reset && (r_occ[w_rv] != '0);
    assign w_is_local   = (w_head[55:48] == 8'd0);
    assign w_hop_dec    = w_head[55:48] - 8'd1;

    assign loc_so = w_head_valid && w_is_local;
    assign fwd_so = w_head_valid && !w_is_local;

    // The data bus reads as zero when nothing is valid. Without that gating,
    // stale memory contents would show up on it.
    always_comb begin
        out_do = 64'h0;
        if (w_head_valid) begin
            if (w_is_local) begin
                out_do = w_head;
            end else begin
                out_do = {w_head[63:56], w_hop_dec, w_head[47:0]};
            end
        end
    end

    // Ready on the port that is not selected has no effect.
    assign w_pop = (loc_so && loc_ro) || (fwd_so && fwd_ro);

    // NOTE: all clocked state uses non-blocking assignments, so every read
    // in this block sees the value from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < 2; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_occ[v]    <= '0;
            end
            r_err_vc <= 1'b0;
        end else begin
            if (w_push) begin
                // Pointers are PTR_W bits wide, so they wrap DEPTH-1 -> 0.
                r_wr_ptr[w_wv] <= r_wr_ptr[w_wv] + 1'b1;
                r_occ[w_wv]    <= r_occ[w_wv] + 1'b1;
                if (in_di[63] != w_wv) begin
                    r_err_vc <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr[w_rv] <= r_rd_ptr[w_rv] + 1'b1;
                r_occ[w_rv]    <= r_occ[w_rv] - 1'b1;
            end
        end
    end

    // NOTE: payload storage has no reset. Occupancy alone decides validity,
    // so clearing the array would add nothing except reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[w_wv][r_wr_ptr[w_wv]] <= in_di;
        end
    end

    assign occ_even = r_occ[0];
    assign occ_odd  = r_occ[1];
    assign err_vc   = r_err_vc;

endmodule

// File: tb/tb_ring_input_buffer.sv
// ----------------------------------------------------------------------------
// tb_ring_input_buffer
//
// Directed bench for ring_input_buffer. Each accepted push places a
// hand-computed expected output into the queue of its VC. A monitor runs on
// the falling edge. Whenever a pop handshake is about to complete, it takes
// the front entry of the read VC's queue and compares it with the port and
// data that the DUT presents.
// ----------------------------------------------------------------------------
module tb_ring_input_buffer;

    typedef struct {
        logic        is_local;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic        in_si;
    logic        in_ri;
    logic [63:0] in_di;
    logic        loc_so;
    logic        loc_ro;
    logic        fwd_so;
    logic        fwd_ro;
    logic [63:0] out_do;
    logic [2:0]  occ_even;
    logic [2:0]  occ_odd;
    logic        err_vc;

    int total = 0;
    int bad   = 0;

    exp_t q_even[$];
    exp_t q_odd[$];

    ring_input_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .in_si    (in_si),
        .in_ri    (in_ri),
        .in_di    (in_di),
        .loc_so   (loc_so),
        .loc_ro   (loc_ro),
        .fwd_so   (fwd_so),
        .fwd_ro   (fwd_ro),
        .out_do   (out_do),
        .occ_even (occ_even),
        .occ_odd  (occ_odd),
        .err_vc   (err_vc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge. Direct checks
    // happen 2 units later, which is still before the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic si, input logic [63:0] di,
                         input logic lr, input logic fr);
        polarity = p;
        in_si    = si;
        in_di    = di;
        loc_ro   = lr;
        fwd_ro   = fr;
        #2;
    endtask

    task automatic expect_pkt(input logic vc, input logic is_local, input logic [63:0] data);
        exp_t e;
        e.is_local = is_local;
        e.data     = data;
        if (vc) q_odd.push_back(e);
        else    q_even.push_back(e);
    endtask

    // Monitor: the read VC is the inverse of polarity.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && ((loc_so && loc_ro) || (fwd_so && fwd_ro))) begin
                exp_t e;
                logic have;
                have = 1'b0;
                if (!polarity) begin
                    if (q_odd.size() > 0) begin
                        e = q_odd.pop_front();
                        have = 1'b1;
                    end
                end else begin
                    if (q_even.size() > 0) begin
                        e = q_even.pop_front();
                        have = 1'b1;
                    end
                end
                if (!have) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got %h expected no output", out_do);
                end else begin
                    check("pop_is_local", {63'h0, loc_so}, {63'h0, e.is_local});
                    check("pop_data", out_do, e.data);
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        polarity = 1'b0;
        in_si    = 1'b0;
        in_di    = 64'h0;
        loc_ro   = 1'b0;
        fwd_ro   = 1'b0;

        // 1: while reset is held, every output must be 0; after release, ready.
        step();
        step();
        drive(0, 1, 64'h0000_0000_0000_0055, 1, 1);
        check("rst_in_ri",  {63'h0, in_ri},  64'h0);
        check("rst_loc_so", {63'h0, loc_so}, 64'h0);
        check("rst_fwd_so", {63'h0, fwd_so}, 64'h0);
        check("rst_out_do", out_do, 64'h0);
        drive(0, 0, 64'h0, 0, 0);
        reset = 1'b1;
        step();
        drive(0, 0, 64'h0, 0, 0);
        check("idle_in_ri",    {63'h0, in_ri},  64'h1);
        check("idle_occ_even", {61'h0, occ_even}, 64'h0);
        check("idle_occ_odd",  {61'h0, occ_odd},  64'h0);
        check("idle_err_vc",   {63'h0, err_vc}, 64'h0);

        // 2: local delivery from the even VC.
        drive(0, 1, 64'h0000_1234_5678_9ABC, 0, 0);
        check("loc_push_ready", {63'h0, in_ri}, 64'h1);
        expect_pkt(1'b0, 1'b1, 64'h0000_1234_5678_9ABC);
        step();
        drive(1, 0, 64'h0, 1, 0);
        check("loc_loc_so",  {63'h0, loc_so}, 64'h1);
        check("loc_fwd_so",  {63'h0, fwd_so}, 64'h0);
        check("loc_out_do",  out_do, 64'h0000_1234_5678_9ABC);
        check("loc_occ_pre", {61'h0, occ_even}, 64'h1);
        step();
        drive(0, 0, 64'h0, 0, 0);
        check("loc_occ_post", {61'h0, occ_even}, 64'h0);

        // 3: forward from the odd VC, with hop 3 decremented to 2.
        step();
        drive(1, 1, 64'h8003_0000_0000_0001, 0, 0);
        expect_pkt(1'b1, 1'b0, 64'h8002_0000_0000_0001);
        step();
        drive(0, 0, 64'h0, 1, 1);
        check("fwd_fwd_so", {63'h0, fwd_so}, 64'h1);
        check("fwd_loc_so", {63'h0, loc_so}, 64'h0);
        check("fwd_out_do", out_do, 64'h8002_0000_0000_0001);
        step();
        drive(1, 0, 64'h0, 0, 0);
        check("fwd_occ_post", {61'h0, occ_odd}, 64'h0);

        // 4: fill the even VC, verify backpressure, then drain.
        for (int i = 1; i <= 4; i++) begin
            step();
            drive(0, 1, 64'h0000_0000_0000_0A00 + 64'(i), 0, 0);
            expect_pkt(1'b0, 1'b1, 64'h0000_0000_0000_0A00 + 64'(i));
            step();
            drive(1, 0, 64'h0, 0, 0);
        end
        check("full_occ_even", {61'h0, occ_even}, 64'h4);
        check("full_head",     out_do, 64'h0000_0000_0000_0A01);
        step();
        drive(0, 1, 64'h0000_0000_0000_0A05, 0, 0);
        check("full_in_ri", {63'h0, in_ri}, 64'h0);
        step();
        drive(1, 0, 64'h0, 1, 0);
        check("full_occ_hold", {61'h0, occ_even}, 64'h4);
        step();
        drive(0, 0, 64'h0, 0, 0);
        check("unfull_in_ri",  {63'h0, in_ri}, 64'h1);
        check("unfull_occ",    {61'h0, occ_even}, 64'h3);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1, 0, 64'h0, 1, 0);
            step();
            drive(0, 0, 64'h0, 0, 0);
        end
        check("drain_occ_even", {61'h0, occ_even}, 64'h0);

        // 5: six packets through the even VC across the pointer wrap.
        for (int i = 1; i <= 6; i++) begin
            step();
            drive(0, 1, 64'(i), 0, 0);
            expect_pkt(1'b0, 1'b1, 64'(i));
            step();
            drive(1, 0, 64'h0, 1, 0);
        end
        step();
        drive(0, 0, 64'h0, 0, 0);
        check("wrap_occ_even", {61'h0, occ_even}, 64'h0);

        // 6: a VC mismatch is stored and flagged. Async reset then clears everything.
        step();
        drive(0, 1, 64'h8000_0000_0000_00EE, 0, 0);
        expect_pkt(1'b0, 1'b1, 64'h8000_0000_0000_00EE);
        step();
        drive(1, 0, 64'h0, 0, 0);
        check("vc_err_set",  {63'h0, err_vc}, 64'h1);
        check("vc_stored",   out_do, 64'h8000_0000_0000_00EE);
        check("vc_occ_even", {61'h0, occ_even}, 64'h1);
        reset = 1'b0;
        q_even.delete();
        q_odd.delete();
        #1;
        check("arst_err_vc",   {63'h0, err_vc}, 64'h0);
        check("arst_occ_even", {61'h0, occ_even}, 64'h0);
        check("arst_loc_so",   {63'h0, loc_so}, 64'h0);
        check("arst_in_ri",    {63'h0, in_ri}, 64'h0);
        step();
        reset = 1'b1;
        step();
        drive(0, 1, 64'h0000_0000_0000_0077, 0, 0);
        check("post_rst_in_ri", {63'h0, in_ri}, 64'h1);
        expect_pkt(1'b0, 1'b1, 64'h0000_0000_0000_0077);
        step();
        drive(1, 0, 64'h0, 1, 0);
        check("post_rst_out_do", out_do, 64'h0000_0000_0000_0077);
        step();
        drive(0, 0, 64'h0, 0, 0);

        check("end_q_even_empty", 64'(q_even.size()), 64'h0);
        check("end_q_odd_empty",  64'(q_odd.size()),  64'h0);
        check("end_err_vc",       {63'h0, err_vc}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
